// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller and its environment.
//   master: drives start/stop/cont/en_mask/dwell and the mux output y.
//   slave : the controller; drives the mux selects s1/s0, sample,
//           smp_valid, frame_done and busy.
interface mux_scan_ctrl_if #(
  parameter int unsigned DWELL_W = 4
);
  logic               start;
  logic               stop;
  logic               cont;
  logic [3:0]         en_mask;
  logic [DWELL_W-1:0] dwell;
  logic               y;
  logic               s1;
  logic               s0;
  logic [3:0]         sample;
  logic               smp_valid;
  logic               frame_done;
  logic               busy;

  modport master (
    output start, stop, cont, en_mask, dwell, y,
    input  s1, s0, sample, smp_valid, frame_done, busy
  );

  modport slave (
    input  start, stop, cont, en_mask, dwell, y,
    output s1, s0, sample, smp_valid, frame_done, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux. Steps the select {s1,s0}
// through the enabled channels, waits dwell+1 settle cycles, then captures
// the mux output y into sample[ch] one cycle later.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_scan_ctrl_if.slave (start/stop/cont/en_mask/dwell/y in;
//           s1/s0/sample/smp_valid/frame_done/busy out, all registered)
module mux_scan_ctrl #(
  parameter int unsigned DWELL_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         mask_q, mask_d;
  logic               cont_q, cont_d;
  logic [3:0]         sample_q, sample_d;
  logic               smp_valid_q, smp_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q;
  logic [2:0]         nxt;

  // Lowest set bit of a non-zero mask.
  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    lowest_ch = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) lowest_ch = 2'(k);
    end
  endfunction

  // {found, channel}: next enabled channel strictly above c.
  function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] c);
    next_ch = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k > int'(c))) next_ch = {1'b1, 2'(k)};
    end
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= 2'd0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      mask_q       <= 4'd0;
      cont_q       <= 1'b0;
      sample_q     <= 4'd0;
      smp_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      mask_q       <= mask_d;
      cont_q       <= cont_d;
      sample_q     <= sample_d;
      smp_valid_q  <= smp_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    mask_d       = mask_q;
    cont_d       = cont_q;
    sample_d     = sample_q;
    smp_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    nxt          = next_ch(mask_q, ch_q);

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.en_mask != 4'd0)) begin
          mask_d  = bus.en_mask;
          dwell_d = bus.dwell;
          cont_d  = bus.cont;
          ch_d    = lowest_ch(bus.en_mask);
          cnt_d   = bus.dwell;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // stop wins over the capture: the aborted channel keeps its old bit.
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          sample_d[ch_q] = bus.y;
          smp_valid_d    = 1'b1;
          if (nxt[2]) begin
            ch_d    = nxt[1:0];
            cnt_d   = dwell_q;
            state_d = SETTLE;
          end else begin
            frame_done_d = 1'b1;
            // Wrap is a latch point: pick up the current mask/dwell/cont.
            if (cont_q && (bus.en_mask != 4'd0)) begin
              mask_d  = bus.en_mask;
              dwell_d = bus.dwell;
              cont_d  = bus.cont;
              ch_d    = lowest_ch(bus.en_mask);
              cnt_d   = bus.dwell;
              state_d = SETTLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.s1         = ch_q[1];
  assign bus.s0         = ch_q[0];
  assign bus.sample     = sample_q;
  assign bus.smp_valid  = smp_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: the stimulus side predicts every
// capture (cycle, sample word, frame_done) from channel lists and dwell
// arithmetic; a monitor pops and compares whenever smp_valid is seen.
module tb_mux_scan_ctrl;
  localparam int unsigned DWELL_W = 4;

  typedef struct {
    int         cyc;
    logic [3:0] smp;
    logic       fd;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] imux;
  int         cyc;
  int         vectors;
  int         miscompares;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] model_sample;
  logic [1:0] model_sel;

  mux_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();
  mux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Behavioural 4:1 mux with inputs i0..i3 = imux[0..3].
  assign bus.y = imux[{bus.s1, bus.s0}];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One scan: start at the next edge; stop_off>0 raises stop so that it is
  // sampled stop_off edges after the start edge.
  task automatic run_scan(input logic [3:0] m, input int d, input bit c,
                          input int stop_off, input bit stop_with_start);
    int chs[$];
    int n;
    int p;
    int e;
    int nj;
    int last;
    int chn;
    for (int k = 0; k < 4; k++) if (m[k]) chs.push_back(k);
    n = chs.size();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.en_mask = m;
    bus.dwell   = DWELL_W'(d);
    bus.cont    = c;
    bus.stop    = stop_with_start;
    p = cyc + 1;
    if (n == 0) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_after_empty_start", bus.busy, 0);
      check("sel_after_empty_start", {bus.s1, bus.s0}, model_sel);
      return;
    end
    if (stop_off > 0) begin
      e    = p + stop_off;
      nj   = (stop_off - 1) / (d + 2);
      last = chs[(((stop_off + d + 1) / (d + 2)) - 1) % n];
    end else begin
      e    = p + n * (d + 2);
      nj   = n;
      last = chs[n-1];
    end
    for (int j = 1; j <= nj; j++) begin
      chn = chs[(j - 1) % n];
      model_sample[chn] = imux[chn];
      exp_q.push_back('{p + j * (d + 2), model_sample, ((j % n) == 0)});
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    if (!c) begin
      // Latched at start: these changes must not disturb the sweep.
      bus.en_mask = 4'($urandom);
      bus.dwell   = DWELL_W'($urandom);
      bus.cont    = 1'($urandom);
    end
    wait_cyc(e - 1);
    check("busy_before_end", bus.busy, 1);
    if (stop_off > 0) bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("busy_after_end", bus.busy, 0);
    check("sel_held_in_idle", {bus.s1, bus.s0}, last);
    model_sel = 2'(last);
    repeat (3) @(negedge clk);
    check("sample_held", bus.sample, model_sample);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Monitor: compare each smp_valid pulse with the oldest prediction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.smp_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_smp_valid: sample=%b frame_done=%b at cycle %0d, none expected",
                   bus.sample, bus.frame_done, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || bus.sample !== mon_e.smp || bus.frame_done !== mon_e.fd) begin
            miscompares++;
            $display("FAIL capture: got cycle %0d sample %b frame_done %b, expected cycle %0d sample %b frame_done %b",
                     cyc, bus.sample, bus.frame_done, mon_e.cyc, mon_e.smp, mon_e.fd);
          end
        end
      end else if (bus.frame_done) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_done_alone: got frame_done=1 without smp_valid at cycle %0d, expected 0", cyc);
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        mon_e = exp_q.pop_front();
        $display("FAIL missed_capture: got no smp_valid, expected one at cycle %0d sample %b", mon_e.cyc, mon_e.smp);
      end
    end
  end

  initial begin
    logic [3:0] m;
    int         d;
    bit         c;
    int         so;
    int         n;
    int         p;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.cont     = 1'b0;
    bus.en_mask  = 4'd0;
    bus.dwell    = '0;
    imux         = 4'd0;
    model_sample = 4'd0;
    model_sel    = 2'd0;
    #1;
    check("reset_outputs", {bus.s1, bus.s0, bus.sample, bus.smp_valid, bus.frame_done, bus.busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_release", bus.busy, 0);

    // Sparse mask, zero dwell: channels 0 and 2 must keep their reset 0.
    imux = 4'b1111;
    run_scan(4'b1010, 0, 1'b0, 0, 1'b0);
    check("sparse_sweep_sample", bus.sample, 4'b1010);

    // Full sweep, dwell 2, with stop raised alongside start in IDLE.
    imux = 4'b1010;
    run_scan(4'b1111, 2, 1'b0, 0, 1'b1);
    check("full_sweep_sample", bus.sample, 4'b1010);

    // Continuous single-channel scan, stopped mid-settle.
    imux = 4'($urandom);
    run_scan(4'b0001, 1, 1'b1, 10, 1'b0);

    // Stop during the settle of channel 2.
    imux = ~model_sample;
    run_scan(4'b1111, 3, 1'b0, 12, 1'b0);

    for (int it = 0; it < 24; it++) begin
      m = 4'($urandom);
      if (it % 6 == 5) m = 4'd0;
      d = int'($urandom_range(0, 5));
      c = ($urandom_range(0, 2) == 0);
      n = $countones(m);
      imux = 4'($urandom);
      if (m == 4'd0) so = 0;
      else if (c) so = int'($urandom_range(1, 40));
      else so = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * (d + 2))) : 0;
      run_scan(m, d, c, so, 1'($urandom));
    end

    // Asynchronous reset in the middle of a continuous scan.
    imux = 4'b1111;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.en_mask = 4'b1111;
    bus.dwell   = DWELL_W'(3);
    bus.cont    = 1'b1;
    p = cyc + 1;
    model_sample[0] = imux[0];
    exp_q.push_back('{p + 5, model_sample, 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.s1, bus.s0, bus.sample, bus.smp_valid, bus.frame_done, bus.busy}, 0);
    exp_q.delete();
    model_sample = 4'd0;
    model_sel    = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_scan_after_release", bus.busy, 0);
    run_scan(4'b0000, 2, 1'b0, 0, 1'b0);
    check("sample_after_reset", bus.sample, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL_W, default 4, width of the dwell-count input.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  level-sampled request to begin a scan; honoured only in IDLE.
REQ-005 Port: stop  input  1  abort; honoured in any non-IDLE state.
REQ-006 Port: cont  input  1  1 = continuous scanning, 0 = single sweep; sampled with start.
REQ-007 Port: en_mask  input  4  channel enable, bit k = mux input ik.
REQ-008 Port: dwell  input  DWELL_W  settle cycles before capture; sampled with start.
REQ-009 Port: y  input  1  output of the downstream 4:1 mux.
REQ-010 Port: s1  output  1  mux select MSB, registered.
REQ-011 Port: s0  output  1  mux select LSB, registered.
REQ-012 Port: sample  output  4  captured value per channel, bit k = last y seen with select k.
REQ-013 Port: smp_valid  output  1  one-cycle pulse after each channel capture.
REQ-014 Port: frame_done  output  1  one-cycle pulse after the last enabled channel of a sweep.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE and CAPTURE, with a 2-bit channel register ch ({s1,s0} = ch) and a DWELL_W-bit down-counter cnt.
REQ-017 IDLE: start=1 and en_mask!=0 -> latch en_mask, dwell and cont; set ch to the lowest enabled channel and cnt to dwell; go to SETTLE.
REQ-018 IDLE: start=1 with en_mask=0 -> remain IDLE with no pulses and outputs unchanged.
REQ-019 SETTLE: cnt!=0 -> cnt decrements; cnt=0 -> go to CAPTURE, so SETTLE lasts dwell+1 cycles (dwell=0 gives 1 cycle).
REQ-020 CAPTURE lasts exactly one cycle; on its exit edge sample[ch] <= y, and smp_valid is 1 in the following cycle.
REQ-021 From CAPTURE: if an enabled channel above ch exists -> ch = next higher enabled channel, cnt = latched dwell, go to SETTLE.
REQ-022 From CAPTURE with no higher enabled channel: frame_done=1 in the same cycle as smp_valid; cont=1 -> re-latch en_mask (en_mask=0 goes to IDLE), wrap ch to its lowest enabled channel, go to SETTLE; cont=0 -> go to IDLE.
REQ-023 Latency per enabled channel SHALL be dwell+2 cycles; one sweep over N enabled channels SHALL take N*(dwell+2) cycles from the start edge to the last capture edge.
REQ-024 s1/s0 SHALL change only on the edge entering SETTLE and be held stable through SETTLE and CAPTURE.
REQ-025 Changes to en_mask, dwell and cont while busy SHALL have no effect until the next latch point (start or wrap).
REQ-026 stop=1 in SETTLE or CAPTURE -> next edge enters IDLE: no sample update, no smp_valid, no frame_done; sample keeps its prior contents.
REQ-027 stop and start both 1 in IDLE -> start is honoured; stop is ignored because the FSM is in IDLE.
REQ-028 Entering IDLE (stop or end of a single sweep) SHALL leave s1/s0 at the last channel; the next start reloads them.
REQ-029 sample bits of disabled channels SHALL hold their previous values.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, force: state IDLE, s1=0, s0=0, sample=4'b0000, smp_valid=0, frame_done=0, busy=0, cnt=0.
REQ-031 Reset asserted mid-scan SHALL abort the scan; after release the block waits in IDLE for start.
REQ-032 Releasing rst_n SHALL not start a scan; start must be sampled high in IDLE afterwards.

Verification
REQ-033 Mux inputs i0..i3=0,1,0,1; en_mask=1111, dwell=2, cont=0, pulse start -> {s1,s0} steps 00,01,10,11 every 4 cycles; sample=4'b1010; 4 smp_valid pulses; frame_done=1 coincides with the 4th pulse; busy drops after 16 cycles.
REQ-034 en_mask=1010, dwell=0, cont=0 -> only selects 01 then 11, 2 cycles each; sample[1]=1, sample[3]=1; sample[0] and sample[2] keep 0.
REQ-035 cont=1, en_mask=0001, dwell=1 -> s stays 00; smp_valid and frame_done pulse together every 3 cycles until stop=1; then IDLE next edge with no further pulses.
REQ-036 Assert stop during the SETTLE of channel 2 -> busy=0 next cycle; sample[2] unchanged; no frame_done.
REQ-037 Drive rst_n=0 between clock edges mid-scan -> all outputs reach their reset values before the next edge; start with en_mask=0 afterwards -> remains IDLE.
